// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN result writeback path: index-width helper,
// LACC transfer size encoding and arbitration mode encodings.
package cnn_pkg;

  localparam logic [1:0] SIZE_WORD   = 2'b10;
  localparam logic       MODE_STRICT = 1'b0;
  localparam logic       MODE_SKIP   = 1'b1;

  function automatic int CH_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_res_writeback_if.sv
// LACC data-port write channel as seen by the result writeback stage.
interface cnn_res_writeback_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CH_W   = 2
);

  logic              bus_busy;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CH_W-1:0]   wr_ch;

  modport master (
    input  bus_busy, wr_ready,
    output wr_valid, wr_addr, wr_data, wr_ch
  );

  modport slave (
    output bus_busy, wr_ready,
    input  wr_valid, wr_addr, wr_data, wr_ch
  );

endinterface

// File: rtl/cnn_res_fifo.sv
// Per-channel result FIFO; head/tail carry an extra wrap bit to tell full from empty.
module cnn_res_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W:0]    head_q, head_d;
  logic [PTR_W:0]    tail_q, tail_d;
  logic              do_push, do_pop;

  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_q[PTR_W] != tail_q[PTR_W]) &&
                   (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[head_q[PTR_W-1:0]];

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PTR_ONE;
      if (do_pop)  head_d = head_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage is data only; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[tail_q[PTR_W-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/cnn_res_writeback.sv
// Buffers per-channel conv/pool results and drains them round-robin to the
// shared LACC data port, with per-channel base address and stride.
module cnn_res_writeback
  import cnn_pkg::*;
#(
  parameter int CH_NUM   = 4,
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int STRIDE_W = 16,
  localparam int CH_W    = CH_IDX_W(CH_NUM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic [STRIDE_W-1:0]      cfg_stride,
  input  logic [CH_NUM-1:0]        in_valid,
  input  logic [CH_NUM*DATA_W-1:0] in_data,
  output logic                     in_stall,
  cnn_res_writeback_if.master      bus,
  output logic                     empty,
  output logic [31:0]              wr_cnt
);

  logic [CH_NUM-1:0] fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [DATA_W-1:0] fifo_rdata [CH_NUM];

  logic [CH_W-1:0]     rr_q, rr_d;
  logic                lock_q, lock_d;
  logic [CH_W-1:0]     lock_ch_q, lock_ch_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   addr_q [CH_NUM];
  logic [ADDR_W-1:0]   addr_d [CH_NUM];
  logic [STRIDE_W-1:0] stride_q [CH_NUM];
  logic [STRIDE_W-1:0] stride_d [CH_NUM];

  logic [CH_W-1:0] grant, scan_idx;
  logic            scan_found;
  logic            hs;

  assign in_stall = |fifo_full;
  assign empty    = &fifo_empty;
  assign wr_cnt   = wr_cnt_q;

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    assign fifo_push[i] = in_valid[i] & ~in_stall & ~flush;
    assign fifo_pop[i]  = hs & ~flush & (grant == CH_W'(i));

    cnn_res_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (flush),
      .push_i  (fifo_push[i]),
      .wdata_i (in_data[i*DATA_W +: DATA_W]),
      .pop_i   (fifo_pop[i]),
      .rdata_o (fifo_rdata[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );
  end

  // A registered lock overrides both modes so a stalled request never changes target.
  always_comb begin
    grant      = rr_q;
    scan_idx   = rr_q;
    scan_found = 1'b0;
    if (lock_q) begin
      grant = lock_ch_q;
    end else if (mode == MODE_SKIP) begin
      for (int k = 0; k < CH_NUM; k++) begin
        scan_idx = CH_W'((int'(rr_q) + k) % CH_NUM);
        if (!scan_found && !fifo_empty[scan_idx]) begin
          grant      = scan_idx;
          scan_found = 1'b1;
        end
      end
    end
  end

  assign bus.wr_valid = ~bus.bus_busy & ~fifo_empty[grant];
  assign bus.wr_ch    = grant;
  assign bus.wr_addr  = addr_q[grant];
  assign bus.wr_data  = fifo_empty[grant] ? '0 : fifo_rdata[grant];
  assign hs           = bus.wr_valid & bus.wr_ready;

  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    wr_cnt_d  = wr_cnt_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    if (flush) begin
      rr_d     = '0;
      lock_d   = 1'b0;
      wr_cnt_d = '0;
    end else begin
      if (hs) begin
        rr_d           = (grant == CH_W'(CH_NUM - 1)) ? '0 : grant + CH_W'(1);
        lock_d         = 1'b0;
        addr_d[grant]  = addr_q[grant] + ADDR_W'(stride_q[grant]);
        if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + 32'd1;
      end else if (bus.wr_valid && !bus.wr_ready) begin
        lock_d    = 1'b1;
        lock_ch_d = grant;
      end
      if (cfg_we) begin
        addr_d[cfg_ch]   = cfg_addr;
        stride_d[cfg_ch] = cfg_stride;
      end
      if (start) begin
        rr_d     = '0;
        lock_d   = 1'b0;
        wr_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q      <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      wr_cnt_q  <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        addr_q[i]   <= '0;
        stride_q[i] <= '0;
      end
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      wr_cnt_q  <= wr_cnt_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
    end
  end

endmodule

// File: tb/tb_cnn_res_writeback.sv
// Scenario bench for cnn_res_writeback: scoreboard of expected writes plus
// per-scenario inline checks of timing, stall, lock and reset/flush behaviour.
module tb_cnn_res_writeback;

  logic         clk = 1'b0;
  logic         rst, flush, start, mode, cfg_we;
  logic [1:0]   cfg_ch;
  logic [31:0]  cfg_addr;
  logic [15:0]  cfg_stride;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic         in_stall, empty;
  logic [31:0]  wr_cnt;

  cnn_res_writeback_if #(.ADDR_W(32), .DATA_W(32), .CH_W(2)) bus ();

  cnn_res_writeback #(
    .CH_NUM(4), .DEPTH(4), .DATA_W(32), .ADDR_W(32), .STRIDE_W(16)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .mode(mode),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_stride(cfg_stride),
    .in_valid(in_valid), .in_data(in_data), .in_stall(in_stall),
    .bus(bus), .empty(empty), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_addr [4];
  logic [31:0] m_stride [4];
  int          n_vec = 0;
  int          n_err = 0;
  bit          ok;

  // Every accepted write is matched in order against the scoreboard.
  always @(negedge clk) begin
    exp_t e, got;
    if (!rst && bus.wr_valid && bus.wr_ready) begin
      got = {bus.wr_ch, bus.wr_addr, bus.wr_data};
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write got ch=%0d addr=%h data=%h, want no write",
                 got.ch, got.addr, got.data);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_err++;
          $display("FAIL write got ch=%0d addr=%h data=%h, want ch=%0d addr=%h data=%h",
                   got.ch, got.addr, got.data, e.ch, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ch, input logic [31:0] d);
    sb.push_back({2'(ch), m_addr[ch], d});
    m_addr[ch] = m_addr[ch] + m_stride[ch];
  endtask

  task automatic set_in(input int ch, input logic [31:0] d);
    in_valid[ch] = 1'b1;
    in_data[ch*32 +: 32] = d;
  endtask

  task automatic wait_drain(output bit done);
    for (int c = 0; c < 40 && sb.size() != 0; c++) tick();
    done = (sb.size() == 0);
  endtask

  task automatic cfg_all;
    for (int i = 0; i < 4; i++) begin
      cfg_we = 1'b1; cfg_ch = 2'(i);
      cfg_addr = 32'h1000 + 32'h100 * i; cfg_stride = 16'd4;
      m_addr[i] = 32'h1000 + 32'h100 * i; m_stride[i] = 32'd4;
      tick();
    end
    cfg_we = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 0; start = 0; mode = 0; cfg_we = 0; cfg_ch = 0;
    cfg_addr = 0; cfg_stride = 0; in_valid = 0; in_data = 0;
    bus.bus_busy = 0; bus.wr_ready = 0;
    #12;
    n_vec++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_wr_valid got %b want 0", bus.wr_valid); end
    n_vec++; if (in_stall !== 1'b0) begin n_err++; $display("FAIL rst_in_stall got %b want 0", in_stall); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", empty); end
    n_vec++; if (bus.wr_ch !== 2'd0) begin n_err++; $display("FAIL rst_wr_ch got %0d want 0", bus.wr_ch); end
    n_vec++; if (bus.wr_addr !== 32'h0) begin n_err++; $display("FAIL rst_wr_addr got %h want 0", bus.wr_addr); end
    n_vec++; if (bus.wr_data !== 32'h0) begin n_err++; $display("FAIL rst_wr_data got %h want 0", bus.wr_data); end
    n_vec++; if (wr_cnt !== 32'h0) begin n_err++; $display("FAIL rst_wr_cnt got %0d want 0", wr_cnt); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic_drain;
    cfg_all();
    mode = 1'b0; bus.wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_in(i, 32'hA0 + i);
      push_exp(i, 32'hA0 + i);
    end
    tick();
    in_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus.wr_valid !== 1'b1 || bus.wr_ch !== 2'(i)) begin
        n_err++;
        $display("FAIL drain_seq got valid=%b ch=%0d, want valid=1 ch=%0d", bus.wr_valid, bus.wr_ch, i);
      end
      tick();
    end
    n_vec++; if (wr_cnt !== 32'd4) begin n_err++; $display("FAIL drain_cnt got %0d want 4", wr_cnt); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %b want 1", empty); end
  endtask

  task automatic test_skip;
    cfg_all();
    mode = 1'b1; bus.wr_ready = 1'b1;
    set_in(2, 32'h55); push_exp(2, 32'h55);
    tick(); in_valid = '0;
    @(negedge clk);
    n_vec++;
    if (bus.wr_valid !== 1'b1 || bus.wr_ch !== 2'd2 || bus.wr_addr !== 32'h1200) begin
      n_err++;
      $display("FAIL skip_latency got valid=%b ch=%0d addr=%h, want valid=1 ch=2 addr=1200",
               bus.wr_valid, bus.wr_ch, bus.wr_addr);
    end
    tick();
    // rr now points at ch3, so ch3 must win over ch0
    set_in(0, 32'h60); set_in(3, 32'h63);
    push_exp(3, 32'h63); push_exp(0, 32'h60);
    tick(); in_valid = '0;
    @(negedge clk);
    n_vec++; if (bus.wr_ch !== 2'd3) begin n_err++; $display("FAIL skip_rr got ch=%0d want 3", bus.wr_ch); end
    wait_drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL skip_drain got %0d pending, want 0", sb.size()); end
    n_vec++; if (wr_cnt !== 32'd3) begin n_err++; $display("FAIL skip_cnt got %0d want 3", wr_cnt); end

    mode = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    set_in(2, 32'h55);
    tick(); in_valid = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL strict_wait got valid=%b want 0", bus.wr_valid); end
      tick();
    end
    set_in(0, 32'h70); set_in(1, 32'h71);
    push_exp(0, 32'h70); push_exp(1, 32'h71); push_exp(2, 32'h55);
    tick(); in_valid = '0;
    wait_drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL strict_drain got %0d pending, want 0", sb.size()); end
  endtask

  task automatic test_full_stall;
    cfg_all();
    mode = 1'b1; bus.wr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(1, 32'hB0 + k);
      if (k < 4) push_exp(1, 32'hB0 + k);
      tick();
      n_vec++;
      if (in_stall !== (k >= 3)) begin
        n_err++;
        $display("FAIL stall_push%0d got %b want %b", k, in_stall, k >= 3);
      end
    end
    in_valid = '0;
    n_vec++; if (bus.wr_valid !== 1'b1 || bus.wr_ch !== 2'd1) begin n_err++; $display("FAIL stall_req got valid=%b ch=%0d want valid=1 ch=1", bus.wr_valid, bus.wr_ch); end
    bus.wr_ready = 1'b1;
    tick();
    n_vec++; if (in_stall !== 1'b0) begin n_err++; $display("FAIL stall_release got %b want 0", in_stall); end
    wait_drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL stall_drain got %0d pending, want 0", sb.size()); end
    repeat (3) tick();
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL stall_empty got %b want 1", empty); end
  endtask

  task automatic test_lock;
    cfg_all();
    mode = 1'b1; bus.wr_ready = 1'b0;
    set_in(3, 32'hC3); push_exp(3, 32'hC3);
    tick(); in_valid = '0;
    set_in(0, 32'hC0); push_exp(0, 32'hC0);
    tick(); in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (bus.wr_valid !== 1'b1 || bus.wr_ch !== 2'd3 || bus.wr_addr !== 32'h1300 || bus.wr_data !== 32'hC3) begin
        n_err++;
        $display("FAIL lock_hold got valid=%b ch=%0d addr=%h data=%h, want 1 3 1300 c3",
                 bus.wr_valid, bus.wr_ch, bus.wr_addr, bus.wr_data);
      end
      tick();
    end
    bus.bus_busy = 1'b1;
    #1;
    n_vec++; if (bus.wr_valid !== 1'b0 || bus.wr_ch !== 2'd3) begin n_err++; $display("FAIL lock_busy got valid=%b ch=%0d want 0 3", bus.wr_valid, bus.wr_ch); end
    tick();
    bus.bus_busy = 1'b0; bus.wr_ready = 1'b1;
    wait_drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL lock_drain got %0d pending, want 0", sb.size()); end
  endtask

  task automatic test_busy_cfg;
    cfg_all();
    mode = 1'b1; bus.wr_ready = 1'b1; bus.bus_busy = 1'b1;
    set_in(0, 32'hD0); push_exp(0, 32'hD0);
    tick(); in_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL busy_valid got %b want 0", bus.wr_valid); end
      tick();
    end
    bus.bus_busy = 1'b0;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 32'h2000; cfg_stride = 16'd4;
    tick();
    cfg_we = 1'b0;
    m_addr[0] = 32'h2000;
    n_vec++; if (sb.size() != 0) begin n_err++; $display("FAIL race_hs got %0d pending, want 0", sb.size()); end
    set_in(0, 32'hD1); push_exp(0, 32'hD1);
    tick(); in_valid = '0;
    wait_drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL race_drain got %0d pending, want 0", sb.size()); end
  endtask

  task automatic test_reset_flush;
    cfg_all();
    mode = 1'b1; bus.wr_ready = 1'b1;
    set_in(1, 32'hE0); push_exp(1, 32'hE0);
    tick(); in_valid = '0;
    wait_drain(ok);
    n_vec++; if (wr_cnt !== 32'd1) begin n_err++; $display("FAIL pre_flush_cnt got %0d want 1", wr_cnt); end
    bus.wr_ready = 1'b0;
    set_in(2, 32'hE2); set_in(3, 32'hE3);
    tick(); in_valid = '0;
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL flush_empty got %b want 1", empty); end
    n_vec++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.wr_valid); end
    n_vec++; if (wr_cnt !== 32'd0) begin n_err++; $display("FAIL flush_cnt got %0d want 0", wr_cnt); end
    bus.wr_ready = 1'b1;
    set_in(1, 32'hE1); push_exp(1, 32'hE1);
    tick(); in_valid = '0;
    wait_drain(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL flush_addr_drain got %0d pending, want 0", sb.size()); end

    bus.wr_ready = 1'b0;
    set_in(2, 32'hE4);
    tick(); in_valid = '0;
    n_vec++; if (bus.wr_valid !== 1'b1) begin n_err++; $display("FAIL pre_rst_valid got %b want 1", bus.wr_valid); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus.wr_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid got %b want 0", bus.wr_valid); end
    n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL async_rst_empty got %b want 1", empty); end
    n_vec++; if (bus.wr_addr !== 32'h0) begin n_err++; $display("FAIL async_rst_addr got %h want 0", bus.wr_addr); end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_skip();
    test_full_stall();
    test_lock();
    test_busy_cfg();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
